// File: rtl/isa_pkg.sv
// RV32 opcode constants and the operand-usage decode shared by the issue logic.
package isa_pkg;

  localparam int REG_W = 5;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_S    = 7'b0100011;

  // Which register fields an instruction format actually reads or writes.
  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic has_rd;
  } opuse_t;

  // Formats outside R/I/LOAD/S carry no tracked operands and pass straight through.
  function automatic opuse_t decode_use(input logic [6:0] opc);
    opuse_t u;
    u = '0;
    case (opc)
      OPC_R: begin
        u.uses_rs1 = 1'b1;
        u.uses_rs2 = 1'b1;
        u.has_rd   = 1'b1;
      end
      OPC_I, OPC_LOAD: begin
        u.uses_rs1 = 1'b1;
        u.has_rd   = 1'b1;
      end
      OPC_S: begin
        u.uses_rs1 = 1'b1;
        u.uses_rs2 = 1'b1;
      end
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/issue_scoreboard_busy_table.sv
// Per-register pending-write flags. A set from issue beats a clear from
// writeback on the same register; x0 is never busy. Lookups treat a register
// being written back this cycle as already resolved (write-first regfile).
module busy_table
  import isa_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic             byp_en,
  input  logic [REG_W-1:0] byp_idx,
  input  logic [REG_W-1:0] rs1_idx,
  input  logic [REG_W-1:0] rs2_idx,
  input  logic [REG_W-1:0] rd_idx,
  output logic             rs1_pend,
  output logic             rs2_pend,
  output logic             rd_pend,
  output logic             byp_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  // Next flag vector: clear first, then set so that set wins; x0 forced clear.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en) busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Flag storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign rs1_pend = (rs1_idx != '0) && busy[rs1_idx] && !(byp_en && (byp_idx == rs1_idx));
  assign rs2_pend = (rs2_idx != '0) && busy[rs2_idx] && !(byp_en && (byp_idx == rs2_idx));
  assign rd_pend  = (rd_idx  != '0) && busy[rd_idx]  && !(byp_en && (byp_idx == rd_idx));

  // Raw flag of the writeback target, used to detect writebacks to idle registers.
  assign byp_busy = busy[byp_idx];

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-to-execute issue controller: holds one instruction for execute,
// blocks on RAW/WAW hazards against pending writers, bounds in-flight writers.
module issue_scoreboard
  import isa_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 4,
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [6:0]       in_opcode,
  input  logic [REG_W-1:0] in_rd,
  input  logic [REG_W-1:0] in_rs1,
  input  logic [REG_W-1:0] in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [REG_W-1:0] out_rd,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             flush,
  output logic [CNT_W-1:0] inflight,
  output logic             err
);

  opuse_t     in_use;
  logic       in_wr;
  logic       out_wr;
  logic       bt_rs1, bt_rs2, bt_rd, wb_busy;
  logic       pend_rs1, pend_rs2, pend_rd;
  logic       handoff, hand_wr, accept, stall, at_cap;
  logic       wb_live, wb_ok, wb_bad;
  logic [CNT_W:0] infl_plus;

  assign in_use = decode_use(in_opcode);
  assign in_wr  = in_use.has_rd && (in_rd != '0);

  assign handoff = out_valid && out_ready && !flush;
  assign hand_wr = handoff && out_wr;

  // Writebacks to x0 are ignored; to an idle register (or with nothing in flight) they only flag err.
  assign wb_live = wb_valid && (wb_rd != '0);
  assign wb_ok   = wb_live && wb_busy && (inflight != '0);
  assign wb_bad  = wb_live && !wb_ok;

  busy_table #(
    .NUM_REGS (NUM_REGS)
  ) u_busy (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (hand_wr),
    .set_idx  (out_rd),
    .clr_en   (wb_ok),
    .clr_idx  (wb_rd),
    .byp_en   (wb_valid),
    .byp_idx  (wb_rd),
    .rs1_idx  (in_rs1),
    .rs2_idx  (in_rs2),
    .rd_idx   (in_rd),
    .rs1_pend (bt_rs1),
    .rs2_pend (bt_rs2),
    .rd_pend  (bt_rd),
    .byp_busy (wb_busy)
  );

  // The held instruction is a writer not yet recorded in the busy table.
  assign pend_rs1 = bt_rs1 || (out_valid && out_wr && (out_rd == in_rs1));
  assign pend_rs2 = bt_rs2 || (out_valid && out_wr && (out_rd == in_rs2));
  assign pend_rd  = bt_rd  || (out_valid && out_wr && (out_rd == in_rd));

  // Cap check counts a writer leaving this cycle but not a same-cycle writeback.
  assign infl_plus = {1'b0, inflight} + {{CNT_W{1'b0}}, hand_wr};
  assign at_cap    = (infl_plus == (CNT_W + 1)'(MAX_INFLIGHT));

  assign stall = (in_use.uses_rs1 && pend_rs1) ||
                 (in_use.uses_rs2 && pend_rs2) ||
                 (in_wr && (pend_rd || at_cap));

  assign in_ready = !flush && !stall && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Output register: flush squashes, accept refills (back-to-back), handoff empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_rd    <= '0;
      out_wr    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= in_instr;
      out_rd    <= in_rd;
      out_wr    <= in_wr;
    end else if (handoff) begin
      out_valid <= 1'b0;
    end
  end

  // In-flight writer count: handoff of a writer increments, valid writeback decrements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({hand_wr, wb_ok})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky protocol error on a writeback with nothing to retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err <= 1'b0;
    else if (wb_bad) err <= 1'b1;
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard with a transaction-level reference model.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [4:0]  out_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [2:0]  inflight;
  logic        err;

  int checks   = 0;
  int failures = 0;

  // Reference state: what the controller must hold, in plain terms.
  bit          mbusy [32];
  int          minfl;
  bit          mov;
  logic [31:0] minstr;
  logic [4:0]  mrd;
  bit          mwr;
  bit          merr;
  logic        seen_ready;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_rd    (out_rd),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .flush     (flush),
    .inflight  (inflight),
    .err       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] add_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return r_op(7'b0000000, rd, rs1, rs2);
  endfunction
  function automatic logic [31:0] sub_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return r_op(7'b0100000, rd, rs1, rs2);
  endfunction
  function automatic logic [31:0] lw_i(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] sw_i(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] lui_i(input logic [4:0] rd);
    return {20'h12345, rd, 7'b0110111};
  endfunction

  function automatic void uses(input logic [6:0] opc, output bit u1, output bit u2, output bit hr);
    u1 = 0; u2 = 0; hr = 0;
    if (opc == 7'b0110011) begin u1 = 1; u2 = 1; hr = 1; end
    else if (opc == 7'b0010011 || opc == 7'b0000011) begin u1 = 1; hr = 1; end
    else if (opc == 7'b0100011) begin u1 = 1; u2 = 1; end
  endfunction

  function automatic bit mpend(input logic [4:0] r, input bit wbv, input logic [4:0] wbr);
    if (r == 5'd0) return 1'b0;
    return (mbusy[r] && !(wbv && wbr == r)) || (mov && mwr && mrd == r);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mbusy[i] = 0;
    minfl = 0; mov = 0; minstr = '0; mrd = '0; mwr = 0; merr = 0;
  endtask

  // One clock: drive, compare on the falling edge, advance the model.
  task automatic step(input bit iv, input logic [31:0] instr, input bit ordy,
                      input bit wbv, input logic [4:0] wbr, input bit fl);
    bit u1, u2, hr, wr, ho, hw, cap, stl, rdy, wbok;
    in_valid  = iv;
    in_instr  = instr;
    in_opcode = instr[6:0];
    in_rs1    = instr[19:15];
    in_rs2    = (instr[6:0] == 7'b0010011 || instr[6:0] == 7'b0000011) ? 5'd0 : instr[24:20];
    in_rd     = (instr[6:0] == 7'b0100011) ? 5'd0 : instr[11:7];
    out_ready = ordy;
    wb_valid  = wbv;
    wb_rd     = wbr;
    flush     = fl;
    @(negedge clk);
    uses(in_opcode, u1, u2, hr);
    wr  = hr && (in_rd != 5'd0);
    ho  = mov && ordy && !fl;
    hw  = ho && mwr;
    cap = (minfl + (hw ? 1 : 0)) == 4;
    stl = (u1 && mpend(in_rs1, wbv, wbr)) || (u2 && mpend(in_rs2, wbv, wbr)) ||
          (wr && (mpend(in_rd, wbv, wbr) || cap));
    rdy = !fl && !stl && (!mov || ordy);
    seen_ready = in_ready;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, mov);
    if (mov) begin
      chk("out_instr", out_instr, minstr);
      chk("out_rd", out_rd, mrd);
    end
    chk("inflight", inflight, minfl);
    chk("err", err, merr);
    wbok = wbv && (wbr != 5'd0) && mbusy[wbr] && (minfl != 0);
    if (wbv && wbr != 5'd0 && !wbok) merr = 1;
    if (wbok) mbusy[wbr] = 0;
    if (hw) mbusy[mrd] = 1;
    minfl = minfl + (hw ? 1 : 0) - (wbok ? 1 : 0);
    if (fl) mov = 0;
    else if (iv && rdy) begin mov = 1; minstr = instr; mrd = in_rd; mwr = wr; end
    else if (ho) mov = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(0, 32'd0, ordy, 0, 5'd0, 0);
  endtask

  task automatic wb(input logic [4:0] r);
    step(0, 32'd0, 1, 1, r, 0);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_instr = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    out_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Back-to-back independent R ops
    step(1, add_i(1, 2, 3), 1, 0, 0, 0);  chk("b2b_ready0", seen_ready, 1);
    step(1, add_i(4, 5, 6), 1, 0, 0, 0);  chk("b2b_ready1", seen_ready, 1);
    idle(1);
    chk("b2b_infl2", inflight, 2);
    wb(5'd1);
    wb(5'd4);
    chk("b2b_infl0", inflight, 0);

    // RAW on a handed-off writer, resolved by same-cycle writeback
    step(1, add_i(1, 2, 3), 1, 0, 0, 0);
    idle(1);
    step(1, sub_i(7, 1, 2), 1, 0, 0, 0);  chk("raw_stall", seen_ready, 0);
    step(1, lui_i(1), 1, 0, 0, 0);        chk("lui_pass", seen_ready, 1);
    step(1, sub_i(7, 1, 2), 1, 0, 0, 0);  chk("raw_stall2", seen_ready, 0);
    step(1, sub_i(7, 1, 2), 1, 1, 5'd1, 0); chk("raw_wb_accept", seen_ready, 1);
    idle(1);
    wb(5'd7);
    chk("raw_infl0", inflight, 0);

    // Store reading a load destination still held in the output register
    step(1, lw_i(1, 2), 0, 0, 0, 0);
    step(1, sw_i(1, 2), 0, 0, 0, 0);      chk("sw_held", seen_ready, 0);
    step(1, sw_i(1, 2), 1, 0, 0, 0);      chk("sw_handoff", seen_ready, 0);
    step(1, sw_i(1, 2), 1, 0, 0, 0);      chk("sw_busy", seen_ready, 0);
    step(1, sw_i(1, 2), 1, 1, 5'd1, 0);   chk("sw_accept", seen_ready, 1);
    idle(1);
    chk("sw_no_rd", inflight, 0);
    step(1, add_i(3, 1, 2), 1, 0, 0, 0);  chk("sw_x1_free", seen_ready, 1);
    idle(1);
    wb(5'd3);

    // In-flight cap
    step(1, add_i(10, 0, 0), 1, 0, 0, 0);
    step(1, add_i(11, 0, 0), 1, 0, 0, 0);
    step(1, add_i(12, 0, 0), 1, 0, 0, 0);
    step(1, add_i(13, 0, 0), 1, 0, 0, 0); chk("cap_fourth", seen_ready, 1);
    step(1, add_i(14, 0, 0), 1, 0, 0, 0); chk("cap_fifth", seen_ready, 0);
    step(1, add_i(14, 0, 0), 1, 0, 0, 0);
    chk("cap_infl4", inflight, 4);
    step(1, add_i(14, 0, 0), 1, 1, 5'd10, 0); chk("cap_wb_cycle", seen_ready, 0);
    step(1, add_i(14, 0, 0), 1, 0, 0, 0); chk("cap_after_wb", seen_ready, 1);
    idle(1);
    chk("cap_infl4b", inflight, 4);
    wb(5'd11); wb(5'd12); wb(5'd13); wb(5'd14);

    // Flush of a held writer
    step(1, add_i(9, 1, 2), 0, 0, 0, 0);
    step(1, add_i(20, 0, 0), 0, 0, 0, 1); chk("flush_ready", seen_ready, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_infl", inflight, 0);
    step(1, add_i(15, 9, 0), 1, 0, 0, 0); chk("flush_x9_free", seen_ready, 1);
    idle(1);
    wb(5'd15);

    // Writeback to an idle register
    wb(5'd5);
    chk("err_set", err, 1);
    idle(1);
    chk("err_sticky", err, 1);

    // Asynchronous reset in the middle of a stall
    step(1, add_i(1, 2, 3), 1, 0, 0, 0);
    idle(1);
    step(1, sub_i(7, 1, 2), 1, 0, 0, 0);  chk("pre_rst_stall", seen_ready, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_instr", out_instr, 0);
    chk("arst_out_rd", out_rd, 0);
    chk("arst_inflight", inflight, 0);
    chk("arst_err", err, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    step(1, sub_i(7, 1, 2), 1, 0, 0, 0);  chk("post_rst_ready", seen_ready, 1);
    idle(1);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
